// File: rtl/max_decode.sv
// rtl/max_decode.sv - max-channel to RGB decoder with 2-entry skid buffer; optional stats via MAX_DECODE_STATS_EN
module max_decode #(
  parameter int ATTEN_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [9:0]  value,
  input  logic [1:0]  index,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  red,
  output logic [9:0]  green,
  output logic [9:0]  blue,
  output logic        err,
  input  logic        stats_clr,
  output logic [15:0] cnt_r,
  output logic [15:0] cnt_g,
  output logic [15:0] cnt_b
);

  logic [29:0] out_pix, skid_pix, new_pix;
  logic        out_full, skid_full, ready_q, err_q;
  logic [9:0]  att;
  logic        accept, legal, out_free;

  always_comb begin
    att = value >> ATTEN_SHIFT;
    case (index)
      2'd0:    new_pix = {value, att, att};
      2'd1:    new_pix = {att, value, att};
      default: new_pix = {att, att, value};
    endcase
  end

  assign legal    = (index != 2'd3);
  assign accept   = ce && in_valid && ready_q;
  // output register can take a new entry when empty or draining this cycle
  assign out_free = !out_full || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_pix   <= '0;
      skid_pix  <= '0;
      out_full  <= 1'b0;
      skid_full <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else if (ce) begin
      if (accept && !legal)
        err_q <= 1'b1;
      if (out_free) begin
        if (skid_full) begin
          out_pix   <= skid_pix;
          out_full  <= 1'b1;
          skid_full <= 1'b0;
          ready_q   <= 1'b1;
        end else if (accept && legal) begin
          out_pix  <= new_pix;
          out_full <= 1'b1;
          ready_q  <= 1'b1;
        end else begin
          out_full <= 1'b0;
          ready_q  <= 1'b1;
        end
      end else if (accept && legal) begin
        // stalled output: park the sample and stop accepting
        skid_pix  <= new_pix;
        skid_full <= 1'b1;
        ready_q   <= 1'b0;
      end else begin
        ready_q <= !skid_full;
      end
    end
  end

  assign in_ready  = ready_q && ce;
  assign out_valid = out_full;
  assign red       = out_pix[29:20];
  assign green     = out_pix[19:10];
  assign blue      = out_pix[9:0];
  assign err       = err_q;

`ifdef MAX_DECODE_STATS_EN
  logic [15:0] cr, cg, cb;

  always_ff @(posedge clk) begin
    if (rst) begin
      cr <= '0;
      cg <= '0;
      cb <= '0;
    end else if (ce) begin
      if (stats_clr) begin
        cr <= '0;
        cg <= '0;
        cb <= '0;
      end else if (accept) begin
        case (index)
          2'd0:    if (cr != 16'hFFFF) cr <= cr + 16'd1;
          2'd1:    if (cg != 16'hFFFF) cg <= cg + 16'd1;
          2'd2:    if (cb != 16'hFFFF) cb <= cb + 16'd1;
          default: ;
        endcase
      end
    end
  end

  assign cnt_r = cr;
  assign cnt_g = cg;
  assign cnt_b = cb;
`else
  logic stats_unused;
  assign stats_unused = stats_clr;
  assign cnt_r = '0;
  assign cnt_g = '0;
  assign cnt_b = '0;
`endif

endmodule

// File: tb/tb_max_decode.sv
// tb/tb_max_decode.sv - directed self-checking bench for max_decode (ATTEN_SHIFT=2)
module tb_max_decode;

  logic        clk = 1'b0;
  logic        rst, ce, in_valid, in_ready, out_valid, out_ready, err, stats_clr;
  logic [9:0]  value, red, green, blue;
  logic [1:0]  index;
  logic [15:0] cnt_r, cnt_g, cnt_b;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  max_decode #(.ATTEN_SHIFT(2)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready),
    .value(value), .index(index),
    .out_valid(out_valid), .out_ready(out_ready),
    .red(red), .green(green), .blue(blue),
    .err(err), .stats_clr(stats_clr),
    .cnt_r(cnt_r), .cnt_g(cnt_g), .cnt_b(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_pix(input string tag, input logic v, input int r, input int g, input int b);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    check({tag, ".red"},   32'(red),   32'(r));
    check({tag, ".green"}, 32'(green), 32'(g));
    check({tag, ".blue"},  32'(blue),  32'(b));
  endtask

  task automatic drive(input logic v, input int val, input int idx);
    in_valid = v;
    value    = 10'(val);
    index    = 2'(idx);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; out_ready = 1'b0; stats_clr = 1'b0;
    drive(1'b0, 0, 0);
    step(); step();
    check_pix("reset", 1'b0, 0, 0, 0);
    check("reset.in_ready", 32'(in_ready), 0);
    check("reset.err", 32'(err), 0);
    check("reset.cnt_r", 32'(cnt_r), 0);
    check("reset.cnt_g", 32'(cnt_g), 0);

    rst = 1'b0;
    step();
    check("post_reset.in_ready", 32'(in_ready), 1);

    // single green sample, latency 1
    out_ready = 1'b1;
    drive(1'b1, 800, 1);
    step();
    check_pix("g800", 1'b1, 200, 800, 200);
    drive(1'b0, 0, 0);
    step();
    check("g800.drain", 32'(out_valid), 0);

    // back-to-back under backpressure
    out_ready = 1'b0;
    drive(1'b1, 100, 0);
    step();
    check_pix("bp.a", 1'b1, 100, 25, 25);
    check("bp.a.in_ready", 32'(in_ready), 1);
    drive(1'b1, 200, 2);
    step();
    check("bp.b.in_ready", 32'(in_ready), 0);
    check_pix("bp.hold1", 1'b1, 100, 25, 25);
    drive(1'b1, 300, 1);
    step();
    check("bp.c.in_ready", 32'(in_ready), 0);
    check_pix("bp.hold2", 1'b1, 100, 25, 25);
    out_ready = 1'b1;
    step();
    check_pix("bp.b", 1'b1, 50, 50, 200);
    check("bp.b.reopen", 32'(in_ready), 1);
    step();
    check_pix("bp.c", 1'b1, 75, 300, 75);
    drive(1'b0, 0, 0);
    step();
    check("bp.drain", 32'(out_valid), 0);

    // illegal index
    drive(1'b1, 5, 3);
    step();
    check("ill.out_valid", 32'(out_valid), 0);
    check("ill.err", 32'(err), 1);
    drive(1'b1, 4, 2);
    step();
    check_pix("ill.next", 1'b1, 1, 1, 4);
    check("ill.err_held", 32'(err), 1);
    drive(1'b0, 0, 0);
    step();

    // reset mid-stream with skid full
    out_ready = 1'b0;
    drive(1'b1, 400, 0);
    step();
    drive(1'b1, 8, 1);
    step();
    check("rst_mid.skid_full", 32'(in_ready), 0);
    check("rst_mid.out_valid", 32'(out_valid), 1);
    rst = 1'b1;
    drive(1'b0, 0, 0);
    step();
    check_pix("rst_mid", 1'b0, 0, 0, 0);
    check("rst_mid.in_ready", 32'(in_ready), 0);
    check("rst_mid.err", 32'(err), 0);
    rst = 1'b0;
    step();
    check("rst_mid.release", 32'(in_ready), 1);
    check("rst_mid.empty", 32'(out_valid), 0);

    // clock-enable freeze
    out_ready = 1'b1;
    drive(1'b1, 40, 0);
    step();
    check_pix("ce.f", 1'b1, 40, 10, 10);
    drive(1'b1, 60, 1);
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_pix("ce.frozen", 1'b1, 40, 10, 10);
      check("ce.in_ready", 32'(in_ready), 0);
    end
    ce = 1'b1;
    step();
    check_pix("ce.g", 1'b1, 15, 60, 15);
    drive(1'b0, 0, 0);
    step();
    check("ce.drain", 32'(out_valid), 0);

`ifdef MAX_DECODE_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    drive(1'b1, 1, 0);
    for (int i = 0; i < 65537; i++) step();
    drive(1'b0, 0, 0);
    step();
    check("stats.sat_r", 32'(cnt_r), 65535);
    drive(1'b1, 1, 1);
    step();
    check("stats.g_one", 32'(cnt_g), 1);
    stats_clr = 1'b1;
    step();
    check("stats.clr_g", 32'(cnt_g), 0);
    check("stats.clr_r", 32'(cnt_r), 0);
    stats_clr = 1'b0;
    drive(1'b0, 0, 0);
    step();
`else
    drive(1'b1, 1, 0);
    step(); step();
    stats_clr = 1'b1;
    drive(1'b1, 1, 1);
    step();
    stats_clr = 1'b0;
    drive(1'b0, 0, 0);
    step();
    check("nostats.cnt_r", 32'(cnt_r), 0);
    check("nostats.cnt_g", 32'(cnt_g), 0);
    check("nostats.cnt_b", 32'(cnt_b), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
